// File: rtl/mmu_unit.sv
// Sv32 translation front-end: translation cache plus two-level page-table walker.
// Define MMU_TLB_EN for a 4-entry fully associative round-robin TLB; otherwise a single-entry cache.
module mmu_unit #(
  parameter logic [3:0] FLUSH_ALL = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  hazard_signal,
  input  logic [31:0] VPC,
  input  logic [31:0] csr_satp,
  input  logic [1:0]  priv,
  input  logic        valid,
  input  logic        sstatus_sum,
  input  logic        access_is_load,
  input  logic        access_is_store,
  input  logic        access_is_inst,
  input  logic        LFM_resolved,
  input  logic [31:0] LFM_word,
  input  logic        MMU_hand_shake,
  output logic [31:0] PC,
  output logic        stall,
  output logic        MMU_busy,
  output logic [31:0] LFM,
  output logic        LFM_enable,
  output logic        instr_fault_mmu,
  output logic        load_fault_mmu,
  output logic        store_fault_mmu,
  output logic [31:0] faulting_va
);

`ifdef MMU_TLB_EN
  localparam int ENTRIES = 4;
`else
  localparam int ENTRIES = 1;
`endif

  typedef enum logic [2:0] {IDLE, L1, L0, DONE, FAULT} state_t;

  state_t state_q, state_nxt;

  logic        virt, flush, satp_chg, hit, start, accept, fill;
  logic [19:0] hit_ppn;
  logic [31:0] satp_q, va_q;
  logic [19:0] ppn_q;
  logic [2:0]  typ_q;
  logic [1:0]  priv_q;
  logic        sum_q, res_q, acc_q;

  logic [ENTRIES-1:0] ent_vld;
  logic [ENTRIES-1:0] fill_sel;
  logic [19:0]        ent_tag [ENTRIES];
  logic [19:0]        ent_ppn [ENTRIES];

  logic pte_v, pte_r, pte_w, pte_x, pte_u, pte_a, pte_d;
  logic pte_bad, pte_leaf, pte_misaligned, perm_bad;
  logic unused_pte_bits;

  assign {pte_d, pte_a, pte_u, pte_x, pte_w, pte_r, pte_v} = {LFM_word[7:6], LFM_word[4:0]};
  assign unused_pte_bits = ^{LFM_word[31:30], LFM_word[9:8], LFM_word[5]};

  assign pte_bad        = !pte_v || (!pte_r && pte_w);
  assign pte_leaf       = pte_r || pte_x;
  assign pte_misaligned = LFM_word[19:10] != 10'd0;

  always_comb begin
    perm_bad = !pte_a;
    if (typ_q[2] && !pte_x) perm_bad = 1'b1;
    if (typ_q[0] && !pte_r) perm_bad = 1'b1;
    if (typ_q[1] && (!pte_w || !pte_d)) perm_bad = 1'b1;
    if (priv_q == 2'b00 && !pte_u) perm_bad = 1'b1;
    if (priv_q != 2'b00 && pte_u && (typ_q[2] || !sum_q)) perm_bad = 1'b1;
  end

  assign virt     = csr_satp[31] && (priv != 2'b11);
  assign flush    = hazard_signal == FLUSH_ALL;
  assign satp_chg = csr_satp != satp_q;
  assign start    = (state_q == IDLE) && virt && valid && !hit && !MMU_hand_shake && !flush;
  // Only a fresh rising edge of LFM_resolved carries a new PTE; held levels are stale.
  assign accept   = ((state_q == L1) || (state_q == L0)) && LFM_resolved && !res_q && !acc_q;
  assign fill     = (state_q == DONE) && !flush;

  assign PC    = (virt && hit) ? {hit_ppn, VPC[11:0]} : VPC;
  assign stall = !rst && virt && valid && !hit && (state_q != FAULT);

  always_comb begin
    hit     = 1'b0;
    hit_ppn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ent_vld[i] && ent_tag[i] == VPC[31:12]) begin
        hit     = 1'b1;
        hit_ppn = hit_ppn | ent_ppn[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: if (start) state_nxt = L1;
      L1: begin
        if (accept) begin
          if (pte_bad)                          state_nxt = FAULT;
          else if (!pte_leaf)                   state_nxt = L0;
          else if (pte_misaligned || perm_bad)  state_nxt = FAULT;
          else                                  state_nxt = DONE;
        end
      end
      L0: if (accept) state_nxt = (pte_bad || !pte_leaf || perm_bad) ? FAULT : DONE;
      DONE:    state_nxt = IDLE;
      FAULT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    MMU_busy        = state_q != IDLE;
    LFM_enable      = 1'b0;
    LFM             = '0;
    instr_fault_mmu = 1'b0;
    load_fault_mmu  = 1'b0;
    store_fault_mmu = 1'b0;
    faulting_va     = '0;
    case (state_q)
      L1: begin
        LFM_enable = !acc_q;
        LFM        = {csr_satp[19:0], 12'h000} + {20'h0, va_q[31:22], 2'b00};
      end
      L0: begin
        LFM_enable = !acc_q;
        LFM        = {ppn_q, 12'h000} + {20'h0, va_q[21:12], 2'b00};
      end
      FAULT: begin
        instr_fault_mmu = typ_q[2];
        store_fault_mmu = typ_q[1];
        load_fault_mmu  = typ_q[0];
        faulting_va     = va_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      satp_q <= csr_satp;
      va_q   <= '0;
      ppn_q  <= '0;
      typ_q  <= '0;
      priv_q <= '0;
      sum_q  <= 1'b0;
      res_q  <= 1'b0;
      acc_q  <= 1'b0;
    end else begin
      satp_q <= csr_satp;
      res_q  <= LFM_resolved;
      acc_q  <= accept;
      if (start) begin
        va_q   <= VPC;
        typ_q  <= {access_is_inst, access_is_store, access_is_load};
        priv_q <= priv;
        sum_q  <= sstatus_sum;
      end
      // An L1 leaf is a superpage: the low PPN half comes from the VA.
      if (accept)
        ppn_q <= (state_q == L1 && pte_leaf) ? {LFM_word[29:20], va_q[21:12]} : LFM_word[29:10];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || satp_chg) ent_vld <= '0;
    else if (fill)       ent_vld <= ent_vld | fill_sel;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (fill && fill_sel[i]) begin
        ent_tag[i] <= va_q[31:12];
        ent_ppn[i] <= ppn_q;
      end
    end
  end

`ifdef MMU_TLB_EN
  logic [1:0] rr_q;
  always_ff @(posedge clk) begin
    if (rst)       rr_q <= '0;
    else if (fill) rr_q <= rr_q + 2'd1;
  end
  assign fill_sel = 4'b0001 << rr_q;
`else
  assign fill_sel = 1'b1;
`endif

endmodule

// File: tb/tb_mmu_unit.sv
// Scoreboarded bench for mmu_unit with a page-table memory responder.
module tb_mmu_unit;
  localparam logic [31:0] SATP  = 32'h8008_0000;
  localparam logic [3:0]  FLUSH = 4'hF;
  localparam logic [2:0]  LD = 3'b001, ST = 3'b010, IF = 3'b100;
  localparam logic [1:0]  PU = 2'b00, PS = 2'b01, PM = 2'b11;
  localparam logic [31:0] PTE_NL = 32'h2000_0C01;

  logic clk = 1'b0, rst;
  logic [3:0] hazard_signal;
  logic [31:0] VPC, csr_satp, LFM_word, PC, LFM, faulting_va;
  logic [1:0] priv;
  logic valid, sstatus_sum, access_is_load, access_is_store, access_is_inst;
  logic LFM_resolved, MMU_hand_shake, stall, MMU_busy, LFM_enable;
  logic instr_fault_mmu, load_fault_mmu, store_fault_mmu;

  always #5 clk = ~clk;

  mmu_unit #(.FLUSH_ALL(FLUSH)) dut (
    .clk(clk), .rst(rst), .hazard_signal(hazard_signal), .VPC(VPC), .csr_satp(csr_satp),
    .priv(priv), .valid(valid), .sstatus_sum(sstatus_sum), .access_is_load(access_is_load),
    .access_is_store(access_is_store), .access_is_inst(access_is_inst),
    .LFM_resolved(LFM_resolved), .LFM_word(LFM_word), .MMU_hand_shake(MMU_hand_shake),
    .PC(PC), .stall(stall), .MMU_busy(MMU_busy), .LFM(LFM), .LFM_enable(LFM_enable),
    .instr_fault_mmu(instr_fault_mmu), .load_fault_mmu(load_fault_mmu),
    .store_fault_mmu(store_fault_mmu), .faulting_va(faulting_va));

  typedef struct {
    bit          fault;
    logic [2:0]  fvec;
    logic [31:0] pa;
    int          n_lfm;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_lfm[$];
  logic [31:0] pte_q[$];
  int n_vec = 0, n_err = 0;
  int lfm_cnt = 0, delay = 0, hold = 0, hold_len = 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] l1a(input logic [31:0] va);
    return {csr_satp[19:0], 12'h000} + {20'h0, va[31:22], 2'b00};
  endfunction

  function automatic logic [31:0] l0a(input logic [31:0] pte, input logic [31:0] va);
    return {pte[29:10], 12'h000} + {20'h0, va[21:12], 2'b00};
  endfunction

  // Page-table memory: answers each request with a delayed LFM_resolved pulse held hold_len cycles.
  initial begin
    LFM_resolved = 1'b0;
    LFM_word = 32'h0;
    forever begin
      @(negedge clk);
      if (hold > 0) begin
        hold--;
        if (hold == 0) LFM_resolved = 1'b0;
      end else if (delay > 0) begin
        delay--;
        if (delay == 0) begin
          if (pte_q.size() > 0) LFM_word = pte_q.pop_front();
          else LFM_word = 32'h0;
          LFM_resolved = 1'b1;
          hold = hold_len;
        end
      end else if (LFM_enable) begin
        lfm_cnt++;
        if (exp_lfm.size() > 0) check("lfm_addr", LFM, exp_lfm.pop_front());
        else check("lfm_extra", {31'h0, LFM_enable}, 32'h0);
        delay = 2;
      end
    end
  end

  task automatic access(input logic [31:0] va, input logic [2:0] typ, input logic [1:0] p,
                        input bit s, input int hs, input exp_t e);
    exp_t got;
    int c0, lat;
    bit done;
    exp_q.push_back(e);
    c0 = lfm_cnt;
    got = e;
    @(negedge clk);
    VPC = va;
    {access_is_inst, access_is_store, access_is_load} = typ;
    priv = p;
    sstatus_sum = s;
    valid = 1'b1;
    MMU_hand_shake = (hs > 0);
    done = 0;
    lat = 0;
    while (!done && lat < 300) begin
      #1;
      if (hs > 0 && lat == hs) begin
        check("hs_busy", {31'h0, MMU_busy}, 32'h0);
        check("hs_stall", {31'h0, stall}, 32'h1);
        MMU_hand_shake = 1'b0;
      end
      if (instr_fault_mmu || load_fault_mmu || store_fault_mmu) begin
        done = 1;
        got = exp_q.pop_front();
        check("is_fault", 32'h1, {31'h0, got.fault});
        check("fault_vec", {29'h0, instr_fault_mmu, store_fault_mmu, load_fault_mmu}, {29'h0, got.fvec});
        check("fault_va", faulting_va, va);
        check("fault_stall", {31'h0, stall}, 32'h0);
        valid = 1'b0;
        @(negedge clk);
        #1;
        check("fault_1cyc", {29'h0, instr_fault_mmu, store_fault_mmu, load_fault_mmu}, 32'h0);
        check("busy_after_fault", {31'h0, MMU_busy}, 32'h0);
      end else if (!stall) begin
        done = 1;
        got = exp_q.pop_front();
        check("is_fault", 32'h0, {31'h0, got.fault});
        check("pa", PC, got.pa);
        if (got.n_lfm == 0) check("hit_latency", lat, 32'h0);
      end
      if (!done) begin
        @(negedge clk);
        lat++;
      end
    end
    if (!done) begin
      check("timeout", lat, 32'h0);
      if (exp_q.size() > 0) got = exp_q.pop_front();
    end
    check("n_lfm", lfm_cnt - c0, got.n_lfm);
    check("lfm_left", exp_lfm.size(), 32'h0);
    exp_lfm.delete();
    valid = 1'b0;
    MMU_hand_shake = 1'b0;
    repeat (2) @(negedge clk);
    pte_q.delete();
  endtask

  task automatic go(input logic [31:0] va, input logic [2:0] typ, input logic [1:0] p, input bit s,
                    input int hs, input int nl, input logic [31:0] pte1, input logic [31:0] pte2,
                    input bit f, input logic [31:0] pa);
    exp_t e;
    if (nl >= 1) begin exp_lfm.push_back(l1a(va));       pte_q.push_back(pte1); end
    if (nl >= 2) begin exp_lfm.push_back(l0a(pte1, va)); pte_q.push_back(pte2); end
    e.fault = f;
    e.fvec  = f ? typ : 3'b000;
    e.pa    = pa;
    e.n_lfm = nl;
    access(va, typ, p, s, hs, e);
  endtask

  task automatic wait_busy(input logic [31:0] want_lfm, output bit seen);
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (MMU_busy && LFM_enable && LFM == want_lfm) seen = 1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    int nfill;
    logic [31:0] va;
    rst = 1'b1; hazard_signal = 4'h0; VPC = 32'h0; csr_satp = SATP; priv = PS;
    valid = 1'b0; sstatus_sum = 1'b0; access_is_load = 1'b0; access_is_store = 1'b0;
    access_is_inst = 1'b0; MMU_hand_shake = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_busy", {31'h0, MMU_busy}, 32'h0);
    check("rst_lfm_en", {31'h0, LFM_enable}, 32'h0);
    check("rst_faults", {29'h0, instr_fault_mmu, store_fault_mmu, load_fault_mmu}, 32'h0);
    check("rst_lfm", LFM, 32'h0);
    check("rst_fva", faulting_va, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Machine mode bypasses translation.
    go(32'h1234_5678, LD, PM, 0, 0, 0, 0, 0, 0, 32'h1234_5678);
    // Two-level walk, then a zero-latency hit.
    go(32'h0040_1234, LD, PS, 0, 0, 2, PTE_NL, 32'h2000_00C7, 0, 32'h8000_0234);
    go(32'h0040_1234, LD, PS, 0, 0, 0, 0, 0, 0, 32'h8000_0234);
    // Store to D=0 page faults without filling; a load then walks and succeeds.
    go(32'h0040_2000, ST, PS, 0, 0, 2, PTE_NL, 32'h2000_0447, 1, 0);
    go(32'h0040_2000, LD, PS, 0, 0, 2, PTE_NL, 32'h2000_0447, 0, 32'h8000_1000);
    // S-mode load of a user page, SUM off then on.
    go(32'h0040_3010, LD, PS, 0, 0, 2, PTE_NL, 32'h2000_0857, 1, 0);
    go(32'h0040_3010, LD, PS, 1, 0, 2, PTE_NL, 32'h2000_0857, 0, 32'h8000_2010);
    // Superpage hit and misaligned superpage.
    go(32'h00C0_0ABC, LD, PS, 0, 0, 1, 32'h2000_00C3, 0, 0, 32'h8000_0ABC);
    go(32'h0100_0123, IF, PS, 0, 0, 1, 32'h2000_04CB, 0, 1, 0);
    // Invalid L1 PTE and non-leaf at L0.
    go(32'h0140_0000, LD, PS, 0, 0, 1, 32'h0000_0000, 0, 1, 0);
    go(32'h0040_4000, LD, PS, 0, 0, 2, PTE_NL, PTE_NL, 1, 0);
    // U-mode on a supervisor page.
    go(32'h0040_8000, LD, PU, 0, 0, 2, PTE_NL, 32'h2000_20C3, 1, 0);
    // Long LFM_resolved level must not be taken as a second PTE.
    hold_len = 3;
    go(32'h0040_5000, LD, PS, 0, 0, 2, PTE_NL, 32'h2000_14C3, 0, 32'h8000_5000);
    hold_len = 1;
    // Walk held off by the handshake.
    go(32'h0040_6000, LD, PS, 0, 4, 2, PTE_NL, 32'h2000_18C3, 0, 32'h8000_6000);

    // FLUSH_ALL while waiting on the L0 PTE.
    va = 32'h0040_7000;
    exp_lfm.push_back(l1a(va)); exp_lfm.push_back(l0a(PTE_NL, va));
    pte_q.push_back(PTE_NL); pte_q.push_back(32'h2000_1CC3);
    @(negedge clk);
    VPC = va; {access_is_inst, access_is_store, access_is_load} = LD; priv = PS; valid = 1'b1;
    wait_busy(l0a(PTE_NL, va), seen);
    check("flush_reached_l0", {31'h0, seen}, 32'h1);
    hazard_signal = FLUSH;
    valid = 1'b0;
    @(negedge clk);
    #1;
    check("flush_busy", {31'h0, MMU_busy}, 32'h0);
    check("flush_faults", {29'h0, instr_fault_mmu, store_fault_mmu, load_fault_mmu}, 32'h0);
    hazard_signal = 4'h0;
    repeat (8) @(negedge clk);
    check("flush_lfm_left", exp_lfm.size(), 32'h0);
    exp_lfm.delete(); pte_q.delete();
    go(va, LD, PS, 0, 0, 2, PTE_NL, 32'h2000_1CC3, 0, 32'h8000_7000);

    // Any satp write invalidates the cache.
    csr_satp = 32'h0;
    @(negedge clk);
    csr_satp = SATP;
    repeat (2) @(negedge clk);
    go(va, LD, PS, 0, 0, 2, PTE_NL, 32'h2000_1CC3, 0, 32'h8000_7000);

    // Reset in the middle of a walk.
    va = 32'h0040_9000;
    exp_lfm.push_back(l1a(va)); pte_q.push_back(PTE_NL);
    @(negedge clk);
    VPC = va; valid = 1'b1;
    wait_busy(l1a(va), seen);
    check("rst_walk_reached", {31'h0, seen}, 32'h1);
    rst = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    #1;
    check("rst_walk_busy", {31'h0, MMU_busy}, 32'h0);
    check("rst_walk_lfm_en", {31'h0, LFM_enable}, 32'h0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    exp_lfm.delete(); pte_q.delete();

    // Capacity: fill distinct pages, last one hits, first one walks again.
`ifdef MMU_TLB_EN
    nfill = 5;
`else
    nfill = 2;
`endif
    for (int i = 0; i < nfill; i++)
      go(32'h0040_0000 | (32'(i + 'h11) << 12), LD, PS, 0, 0, 2, PTE_NL,
         (32'(32'h80010 + i) << 10) | 32'hC3, 0, 32'(32'h80010 + i) << 12);
    go(32'h0040_0000 | (32'(nfill - 1 + 'h11) << 12), LD, PS, 0, 0, 0, 0, 0, 0,
       32'(32'h80010 + nfill - 1) << 12);
    go(32'h0041_1000, LD, PS, 0, 0, 2, PTE_NL, 32'h2000_40C3, 0, 32'h8001_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
